// File: rtl/writeback_commit.sv
// Writeback/commit stage: gathers out-of-order execute results into a slot window
// and retires them in index order to the GRF or store path, then handshakes window end.
module writeback_commit #(
    parameter int  WINDOW = 16,
    parameter int  N_ALU  = 16,
    parameter int  N_MD   = 4,
    parameter int  XLEN   = 32,
    localparam int IW     = $clog2(WINDOW)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_ALU-1:0]           alu_valid_i,
    input  logic [N_ALU-1:0][4:0]      alu_areg_i,
    input  logic [N_ALU-1:0][XLEN-1:0] alu_data_i,
    input  logic [N_MD-1:0]            md_valid_i,
    input  logic [N_MD-1:0][IW-1:0]    md_idx_i,
    input  logic [N_MD-1:0][4:0]       md_areg_i,
    input  logic [N_MD-1:0][XLEN-1:0]  md_data_i,
    input  logic                       lsa_valid_i,
    input  logic [IW-1:0]              lsa_idx_i,
    input  logic                       lsa_store_i,
    input  logic [4:0]                 lsa_areg_i,
    input  logic [XLEN-1:0]            lsa_data_i,
    input  logic                       csr_valid_i,
    input  logic [IW-1:0]              csr_idx_i,
    input  logic [4:0]                 csr_areg_i,
    input  logic [XLEN-1:0]            csr_data_i,
    input  logic                       exc_i,
    input  logic [IW-1:0]              exc_idx_i,
    input  logic                       mret_i,
    input  logic                       br_i,
    input  logic [IW-1:0]              br_idx_i,
    output logic                       grf_valid_o,
    input  logic                       grf_ready_i,
    output logic [4:0]                 grf_areg_o,
    output logic [XLEN-1:0]            grf_data_o,
    output logic                       st_valid_o,
    input  logic                       st_ready_i,
    output logic [IW-1:0]              st_idx_o,
    output logic                       int_valid_o,
    input  logic                       int_ready_i,
    output logic                       cycle_end_o,
    output logic                       err_dup_o
);

    typedef enum logic [0:0] {S_RUN = 1'b0, S_END = 1'b1} state_t;

    localparam logic [IW:0] WIN_END = (IW+1)'(WINDOW);
    localparam logic [IW:0] ONE     = (IW+1)'(1);

    state_t                   state_q, state_d;
    logic [IW:0]              head_q, head_d;
    logic [WINDOW-1:0]        vld_q, st_q;
    logic [WINDOW-1:0][4:0]   areg_q;
    logic [WINDOW-1:0][XLEN-1:0] data_q;
    logic                     err_q;

    logic [WINDOW-1:0]        wr_s, wst_s, dup_s;
    logic [WINDOW-1:0][4:0]   wareg_s;
    logic [WINDOW-1:0][XLEN-1:0] wdata_s;
    logic                     clear_s;
    logic [IW:0]              end_s;
    logic                     fast_end_s;
    logic [IW-1:0]            hidx_s;

    // Window end index; exceptions and full windows may end on the accepting cycle.
    always_comb begin
        end_s = WIN_END;
        if (exc_i) begin
            end_s = {1'b0, exc_idx_i};
        end else if (mret_i) begin
            end_s = {1'b0, csr_idx_i} + ONE;
        end else if (br_i) begin
            end_s = {1'b0, br_idx_i} + ONE;
        end else begin
            end_s = WIN_END;
        end
        fast_end_s = exc_i | ~(mret_i | br_i);
    end

    // Per-slot write arbitration: lowest-priority source first so higher ones overwrite.
    always_comb begin
        logic hit_v;
        logic multi_v;
        logic occ_v;
        wr_s    = '0;
        wst_s   = '0;
        dup_s   = '0;
        wareg_s = '0;
        wdata_s = '0;
        hit_v   = 1'b0;
        multi_v = 1'b0;
        occ_v   = 1'b0;
        for (int s = 0; s < WINDOW; s++) begin
            hit_v   = 1'b0;
            multi_v = 1'b0;
            if (s < N_ALU && alu_valid_i[s]) begin
                hit_v      = 1'b1;
                wst_s[s]   = 1'b0;
                wareg_s[s] = alu_areg_i[s];
                wdata_s[s] = alu_data_i[s];
            end else begin
                hit_v = 1'b0;
            end
            for (int m = N_MD - 1; m >= 0; m--) begin
                if (md_valid_i[m] && md_idx_i[m] == IW'(s)) begin
                    multi_v    = multi_v | hit_v;
                    hit_v      = 1'b1;
                    wst_s[s]   = 1'b0;
                    wareg_s[s] = md_areg_i[m];
                    wdata_s[s] = md_data_i[m];
                end else begin
                    multi_v = multi_v;
                end
            end
            if (csr_valid_i && csr_idx_i == IW'(s)) begin
                multi_v    = multi_v | hit_v;
                hit_v      = 1'b1;
                wst_s[s]   = 1'b0;
                wareg_s[s] = csr_areg_i;
                wdata_s[s] = csr_data_i;
            end else begin
                multi_v = multi_v;
            end
            if (lsa_valid_i && lsa_idx_i == IW'(s)) begin
                multi_v    = multi_v | hit_v;
                hit_v      = 1'b1;
                wst_s[s]   = lsa_store_i;
                wareg_s[s] = lsa_areg_i;
                wdata_s[s] = lsa_data_i;
            end else begin
                multi_v = multi_v;
            end
            // On the clear cycle old contents vanish, so a write there opens the next window.
            occ_v    = vld_q[s] & ~clear_s;
            wr_s[s]  = hit_v & ~occ_v;
            dup_s[s] = multi_v | (hit_v & occ_v);
        end
    end

    assign hidx_s = head_q[IW-1:0];

    // Commit FSM: next state, head advance and handshake outputs.
    always_comb begin
        state_d     = state_q;
        head_d      = head_q;
        clear_s     = 1'b0;
        grf_valid_o = 1'b0;
        grf_areg_o  = 5'd0;
        grf_data_o  = '0;
        st_valid_o  = 1'b0;
        st_idx_o    = '0;
        int_valid_o = 1'b0;
        cycle_end_o = 1'b0;
        case (state_q)
            S_RUN: begin
                if (head_q >= end_s) begin
                    state_d = S_END;
                end else if (vld_q[hidx_s]) begin
                    if (st_q[hidx_s]) begin
                        st_valid_o = 1'b1;
                        st_idx_o   = hidx_s;
                        head_d     = st_ready_i ? head_q + ONE : head_q;
                    end else if (areg_q[hidx_s] != 5'd0) begin
                        grf_valid_o = 1'b1;
                        grf_areg_o  = areg_q[hidx_s];
                        grf_data_o  = data_q[hidx_s];
                        head_d      = grf_ready_i ? head_q + ONE : head_q;
                    end else begin
                        head_d = head_q + ONE;
                    end
                    if (fast_end_s && head_d != head_q && head_d >= end_s) begin
                        state_d = S_END;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            S_END: begin
                int_valid_o = 1'b1;
                if (int_ready_i) begin
                    cycle_end_o = 1'b1;
                    clear_s     = 1'b1;
                    head_d      = '0;
                    state_d     = S_RUN;
                end else begin
                    state_d = S_END;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State, head, slot array and duplicate-write pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_RUN;
            head_q  <= '0;
            vld_q   <= '0;
            st_q    <= '0;
            areg_q  <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            err_q   <= |dup_s;
            for (int s = 0; s < WINDOW; s++) begin
                if (wr_s[s]) begin
                    vld_q[s]  <= 1'b1;
                    st_q[s]   <= wst_s[s];
                    areg_q[s] <= wareg_s[s];
                    data_q[s] <= wdata_s[s];
                end else if (clear_s) begin
                    vld_q[s] <= 1'b0;
                end else begin
                    vld_q[s] <= vld_q[s];
                end
            end
        end
    end

    assign err_dup_o = err_q;

endmodule

// File: tb/tb_writeback_commit.sv
// Directed bench for writeback_commit: scoreboard of expected commits in index order,
// popped whenever the GRF or store handshake completes.
module tb_writeback_commit;
    localparam int W  = 16;
    localparam int NA = 16;
    localparam int NM = 4;
    localparam int XL = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NA-1:0] alu_valid_i;
    logic [NA-1:0][4:0] alu_areg_i;
    logic [NA-1:0][XL-1:0] alu_data_i;
    logic [NM-1:0] md_valid_i;
    logic [NM-1:0][IW-1:0] md_idx_i;
    logic [NM-1:0][4:0] md_areg_i;
    logic [NM-1:0][XL-1:0] md_data_i;
    logic lsa_valid_i, lsa_store_i, csr_valid_i, exc_i, mret_i, br_i;
    logic [IW-1:0] lsa_idx_i, csr_idx_i, exc_idx_i, br_idx_i;
    logic [4:0] lsa_areg_i, csr_areg_i;
    logic [XL-1:0] lsa_data_i, csr_data_i;
    logic grf_valid_o, grf_ready_i, st_valid_o, st_ready_i;
    logic int_valid_o, int_ready_i, cycle_end_o, err_dup_o;
    logic [4:0] grf_areg_o;
    logic [XL-1:0] grf_data_o;
    logic [IW-1:0] st_idx_o;

    writeback_commit #(.WINDOW(W), .N_ALU(NA), .N_MD(NM), .XLEN(XL)) dut (
        .clk(clk), .rst(rst),
        .alu_valid_i(alu_valid_i), .alu_areg_i(alu_areg_i), .alu_data_i(alu_data_i),
        .md_valid_i(md_valid_i), .md_idx_i(md_idx_i), .md_areg_i(md_areg_i), .md_data_i(md_data_i),
        .lsa_valid_i(lsa_valid_i), .lsa_idx_i(lsa_idx_i), .lsa_store_i(lsa_store_i),
        .lsa_areg_i(lsa_areg_i), .lsa_data_i(lsa_data_i),
        .csr_valid_i(csr_valid_i), .csr_idx_i(csr_idx_i), .csr_areg_i(csr_areg_i), .csr_data_i(csr_data_i),
        .exc_i(exc_i), .exc_idx_i(exc_idx_i), .mret_i(mret_i), .br_i(br_i), .br_idx_i(br_idx_i),
        .grf_valid_o(grf_valid_o), .grf_ready_i(grf_ready_i), .grf_areg_o(grf_areg_o), .grf_data_o(grf_data_o),
        .st_valid_o(st_valid_o), .st_ready_i(st_ready_i), .st_idx_o(st_idx_o),
        .int_valid_o(int_valid_o), .int_ready_i(int_ready_i),
        .cycle_end_o(cycle_end_o), .err_dup_o(err_dup_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_st;
        logic [4:0]  areg;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int errors = 0;
    int checks = 0;
    int ncommit = 0;
    int ndup = 0;
    int c0, d0;
    logic s_gv, s_sv, s_int, s_cend, s_dup;
    logic [4:0] s_garea;
    logic [31:0] s_gdata;
    logic [IW-1:0] s_sidx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_grf(input int areg, input int data);
        exp_t e;
        e.is_st = 1'b0; e.areg = 5'(areg); e.data = 32'(data);
        sb.push_back(e);
    endtask

    task automatic push_st(input int idx);
        exp_t e;
        e.is_st = 1'b1; e.areg = 5'd0; e.data = 32'(idx);
        sb.push_back(e);
    endtask

    task automatic sample();
        exp_t e;
        s_gv = grf_valid_o; s_sv = st_valid_o; s_int = int_valid_o;
        s_cend = cycle_end_o; s_dup = err_dup_o;
        s_garea = grf_areg_o; s_gdata = grf_data_o; s_sidx = st_idx_o;
        if (err_dup_o === 1'b1) ndup++;
        if (grf_valid_o === 1'b1 && grf_ready_i) begin
            chk("grf_commit_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("grf_kind", {31'd0, e.is_st}, 32'd0);
                chk("grf_areg", {27'd0, grf_areg_o}, {27'd0, e.areg});
                chk("grf_data", grf_data_o, e.data);
                ncommit++;
            end
        end
        if (st_valid_o === 1'b1 && st_ready_i) begin
            chk("st_commit_expected", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("st_kind", {31'd0, e.is_st}, 32'd1);
                chk("st_idx", {28'd0, st_idx_o}, e.data);
                ncommit++;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid_i = '0; md_valid_i = '0; lsa_valid_i = 1'b0; csr_valid_i = 1'b0;
        lsa_store_i = 1'b0;
    endtask

    task automatic end_window(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = (s_int === 1'b1);
        end
        chk({tag, "_int_valid"}, {31'd0, seen}, 32'd1);
        int_ready_i = 1'b1;
        cyc();
        chk({tag, "_cycle_end"}, {31'd0, s_cend}, 32'd1);
        int_ready_i = 1'b0;
        exc_i = 1'b0; mret_i = 1'b0; br_i = 1'b0;
        chk({tag, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        alu_areg_i = '0; alu_data_i = '0; md_idx_i = '0; md_areg_i = '0; md_data_i = '0;
        lsa_idx_i = '0; lsa_areg_i = '0; lsa_data_i = '0;
        csr_idx_i = '0; csr_areg_i = '0; csr_data_i = '0;
        exc_i = 1'b0; exc_idx_i = '0; mret_i = 1'b0; br_i = 1'b0; br_idx_i = '0;
        grf_ready_i = 1'b1; st_ready_i = 1'b1; int_ready_i = 1'b0;
        idle();
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("reset_grf_valid", {31'd0, s_gv}, 32'd0);
        chk("reset_st_valid", {31'd0, s_sv}, 32'd0);
        chk("reset_int_valid", {31'd0, s_int}, 32'd0);
        chk("reset_err_dup", {31'd0, s_dup}, 32'd0);

        // full window, in order
        for (int k = 0; k < 16; k++) begin
            alu_valid_i[k] = 1'b1; alu_areg_i[k] = 5'(k + 1); alu_data_i[k] = 32'h100 + 32'(k);
            push_grf(k + 1, 32'h100 + k);
        end
        cyc(); idle();
        c0 = ncommit;
        for (int i = 0; i < 16; i++) begin
            cyc();
            chk("t1_grf_valid_each_cycle", {31'd0, s_gv}, 32'd1);
        end
        chk("t1_commits", ncommit - c0, 32'd16);
        cyc();
        chk("t1_int_valid_next", {31'd0, s_int}, 32'd1);
        chk("t1_no_cycle_end_yet", {31'd0, s_cend}, 32'd0);
        int_ready_i = 1'b1;
        cyc();
        chk("t1_cycle_end", {31'd0, s_cend}, 32'd1);
        int_ready_i = 1'b0;
        cyc();
        chk("t1_int_dropped", {31'd0, s_int}, 32'd0);
        chk("t1_cycle_end_pulse", {31'd0, s_cend}, 32'd0);

        // out-of-order writes 3,1,2,0, window ends at branch slot 3
        br_i = 1'b1; br_idx_i = 4'd3;
        for (int k = 0; k < 4; k++) push_grf(20 + k, 32'h300 + k);
        c0 = ncommit;
        for (int j = 0; j < 4; j++) begin
            int k;
            k = (j == 0) ? 3 : (j == 1) ? 1 : (j == 2) ? 2 : 0;
            idle();
            alu_valid_i[k] = 1'b1; alu_areg_i[k] = 5'(20 + k); alu_data_i[k] = 32'h300 + 32'(k);
            cyc();
        end
        idle();
        chk("t2_no_early_commit", ncommit - c0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t2_back_to_back", {31'd0, s_gv}, 32'd1);
        end
        cyc();
        chk("t2_branch_int_latency", {31'd0, s_int}, 32'd0);
        end_window("t2");

        // store / skip mix with stalled store path
        st_ready_i = 1'b0; br_i = 1'b1; br_idx_i = 4'd2;
        alu_valid_i[0] = 1'b1; alu_areg_i[0] = 5'd7; alu_data_i[0] = 32'h77;
        alu_valid_i[1] = 1'b1; alu_areg_i[1] = 5'd0; alu_data_i[1] = 32'h55;
        lsa_valid_i = 1'b1; lsa_idx_i = 4'd2; lsa_store_i = 1'b1; lsa_areg_i = 5'd3; lsa_data_i = 32'h99;
        push_grf(7, 32'h77); push_st(2);
        cyc(); idle();
        cyc();
        cyc();
        chk("t3_skip_no_grf", {31'd0, s_gv}, 32'd0);
        chk("t3_skip_no_st", {31'd0, s_sv}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_st_valid_held", {31'd0, s_sv}, 32'd1);
            chk("t3_st_idx_held", {28'd0, s_sidx}, 32'd2);
        end
        st_ready_i = 1'b1;
        cyc();
        end_window("t3");

        // exception at slot 5 with slots 0..7 valid, plus a rewrite of valid slot 6
        exc_i = 1'b1; exc_idx_i = 4'd5;
        for (int k = 0; k < 8; k++) begin
            alu_valid_i[k] = 1'b1; alu_areg_i[k] = 5'(k + 1); alu_data_i[k] = 32'h200 + 32'(k);
        end
        for (int k = 0; k < 5; k++) push_grf(k + 1, 32'h200 + k);
        c0 = ncommit; d0 = ndup;
        cyc(); idle();
        alu_valid_i[6] = 1'b1; alu_data_i[6] = 32'hDEAD;
        cyc(); idle();
        end_window("t4");
        chk("t4_commits", ncommit - c0, 32'd5);
        chk("t4_dup_rewrite", ndup - d0, 32'd1);

        // exception at slot 0: nothing commits
        exc_i = 1'b1; exc_idx_i = 4'd0;
        for (int k = 0; k < 4; k++) begin
            alu_valid_i[k] = 1'b1; alu_areg_i[k] = 5'(k + 1); alu_data_i[k] = 32'hE0 + 32'(k);
        end
        c0 = ncommit;
        cyc(); idle();
        end_window("t4b");
        chk("t4b_no_commits", ncommit - c0, 32'd0);

        // branch at 3 and mret at 6 together: mret wins, slot 6 (areg 0) skipped
        br_i = 1'b1; br_idx_i = 4'd3; mret_i = 1'b1;
        csr_valid_i = 1'b1; csr_idx_i = 4'd6; csr_areg_i = 5'd0; csr_data_i = 32'hC5;
        for (int k = 0; k < 8; k++) begin
            if (k != 6) begin
                alu_valid_i[k] = 1'b1; alu_areg_i[k] = 5'(k + 1); alu_data_i[k] = 32'h400 + 32'(k);
            end
        end
        for (int k = 0; k < 6; k++) push_grf(k + 1, 32'h400 + k);
        c0 = ncommit;
        cyc(); idle();
        end_window("t5");
        chk("t5_commits", ncommit - c0, 32'd6);

        // lsa and md0 collide on slot 4: lsa wins, one err_dup pulse
        br_i = 1'b1; br_idx_i = 4'd4;
        for (int k = 0; k < 4; k++) begin
            alu_valid_i[k] = 1'b1; alu_areg_i[k] = 5'(11 + k); alu_data_i[k] = 32'h500 + 32'(k);
            push_grf(11 + k, 32'h500 + k);
        end
        lsa_valid_i = 1'b1; lsa_idx_i = 4'd4; lsa_store_i = 1'b0; lsa_areg_i = 5'd9; lsa_data_i = 32'hAAAA;
        md_valid_i[0] = 1'b1; md_idx_i[0] = 4'd4; md_areg_i[0] = 5'd10; md_data_i[0] = 32'hBBBB;
        push_grf(9, 32'hAAAA);
        c0 = ncommit; d0 = ndup;
        cyc(); idle();
        end_window("t6");
        chk("t6_commits", ncommit - c0, 32'd5);
        chk("t6_dup_pulses", ndup - d0, 32'd1);

        // reset mid-commit discards everything
        for (int k = 0; k < 8; k++) begin
            alu_valid_i[k] = 1'b1; alu_areg_i[k] = 5'(1 + k); alu_data_i[k] = 32'h600 + 32'(k);
        end
        push_grf(1, 32'h600); push_grf(2, 32'h601);
        cyc(); idle();
        cyc(); cyc();
        grf_ready_i = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0; grf_ready_i = 1'b1;
        cyc();
        chk("t7_grf_valid", {31'd0, s_gv}, 32'd0);
        chk("t7_grf_areg", {27'd0, s_garea}, 32'd0);
        chk("t7_grf_data", s_gdata, 32'd0);
        chk("t7_st_valid", {31'd0, s_sv}, 32'd0);
        chk("t7_int_valid", {31'd0, s_int}, 32'd0);
        chk("t7_cycle_end", {31'd0, s_cend}, 32'd0);
        chk("t7_err_dup", {31'd0, s_dup}, 32'd0);
        c0 = ncommit;
        cyc(); cyc(); cyc();
        chk("t7_no_commits_after_reset", ncommit - c0, 32'd0);
        chk("t7_sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
